// File: rtl/counting_tx.sv
// counting_tx: frame transmitter for the 2-bit `num` symbol stream.
// A frame is the preamble 1,2,3, then up to MAX_LEN caller-supplied nonzero
// payload symbols taken over a valid/ready handshake, then a terminating 0.
//
// Optional build macro: COUNTING_TX_FILL_EN
//   defined   - a payload underflow (ready && !valid) sends a filler 3 and the
//               frame continues until the full count has been accepted.
//   undefined - a payload underflow aborts the frame straight to GAP.
//   Either way, an underflow sets err.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   start      frame request, sampled only in IDLE
//   len        payload length, captured with start (saturates to MAX_LEN)
//   sym_valid  payload symbol available
//   sym_in     payload symbol
//   sym_ready  transmitter accepts sym_in this cycle (decoded from state/count)
//   num        registered symbol stream
//   busy       high in every state except IDLE
//   done       one-cycle pulse while in GAP
//   err        sticky protocol error, cleared when a start is accepted
//
// LEN_W must satisfy 2**LEN_W > MAX_LEN.
module counting_tx #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sym_valid,
    input  logic [1:0]       sym_in,
    output logic             sym_ready,
    output logic [1:0]       num,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE1 = 3'd1,
        PRE2 = 3'd2,
        PRE3 = 3'd3,
        PAY  = 3'd4,
        GAP  = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_nx;
    logic [1:0]       num_nx;
    logic             err_nx;

    // Payload slots exist in PRE3 and PAY while symbols remain to be taken.
    assign sym_ready = ((state == PRE3) || (state == PAY)) && (rem != '0);

    // Next-state logic; num_nx is the symbol to show in the next state.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        num_nx   = 2'd0;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = PRE1;
                    num_nx   = 2'd1;
                    rem_nx   = (len > MAX_LEN_W) ? MAX_LEN_W : len;
                    err_nx   = 1'b0;
                end
            end
            PRE1: begin
                state_nx = PRE2;
                num_nx   = 2'd2;
            end
            PRE2: begin
                state_nx = PRE3;
                num_nx   = 2'd3;
            end
            PRE3, PAY: begin
                if (!sym_ready) begin
                    state_nx = GAP;
                end else if (sym_valid) begin
                    state_nx = PAY;
                    rem_nx   = rem - LEN_W'(1);
                    // A zero symbol would end the frame early at the receiver.
                    if (sym_in == 2'd0) begin
                        num_nx = 2'd3;
                        err_nx = 1'b1;
                    end else begin
                        num_nx = sym_in;
                    end
                end else begin
`ifdef COUNTING_TX_FILL_EN
                    state_nx = PAY;
                    num_nx   = 2'd3;
                    err_nx   = 1'b1;
`else
                    state_nx = GAP;
                    num_nx   = 2'd0;
                    rem_nx   = '0;
                    err_nx   = 1'b1;
`endif
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            num   <= 2'd0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            num   <= num_nx;
            err   <= err_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == GAP);
        end
    end

endmodule

// File: tb/tb_counting_tx.sv
module tb_counting_tx;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             sym_valid;
    logic [1:0]       sym_in;
    logic             sym_ready;
    logic [1:0]       num;
    logic             busy;
    logic             done;
    logic             err;

    counting_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .sym_valid (sym_valid),
        .sym_in    (sym_in),
        .sym_ready (sym_ready),
        .num       (num),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One expected cycle of a frame, PRE1 through GAP, plus the inputs to drive.
    typedef struct {
        int nm;
        bit rdy;
        bit dn;
        bit er;
        bit dv;
        int ds;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t ents[$];
    int   f_syms[$];
    bit   f_vpat[$];
    int   obs_num[$];
    bit   m_err = 1'b0;
    int   m_acc;

    function automatic void add(input int nm, input bit rdy, input bit dn,
                                input bit er, input bit dv, input int ds);
        ent_t e;
        e.nm = nm; e.rdy = rdy; e.dn = dn; e.er = er; e.dv = dv; e.ds = ds;
        ents.push_back(e);
    endfunction

    // Reference: walk the payload slots symbol by symbol from the frame rules.
    function automatic void build_model(input int len_i);
        int n, acc, k, cur, s;
        bit going, v;
        n = (len_i > int'(MAX_LEN)) ? int'(MAX_LEN) : len_i;
        ents.delete();
        m_err = 1'b0;
        add(1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        add(2, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        cur = 3; acc = 0; k = 0; going = 1'b1;
        while (going) begin
            v = (k < f_vpat.size()) ? f_vpat[k] : 1'b1;
            s = (acc < f_syms.size()) ? f_syms[acc] : 1;
            if (acc < n) begin
                add(cur, 1'b1, 1'b0, m_err, v, s);
                if (v) begin
                    cur = (s == 0) ? 3 : s;
                    if (s == 0) m_err = 1'b1;
                    acc++;
                end else begin
`ifdef COUNTING_TX_FILL_EN
                    cur = 3;
                    m_err = 1'b1;
`else
                    m_err = 1'b1;
                    going = 1'b0;
`endif
                end
            end else begin
                add(cur, 1'b0, 1'b0, m_err, 1'b1, 1);
                going = 1'b0;
            end
            k++;
        end
        add(0, 1'b0, 1'b1, m_err, 1'b1, 2);
        m_acc = acc;
    endfunction

    // Runs one frame from IDLE; entered and left #1 after a posedge.
    task automatic run_frame(input string tag, input int len_i, input bit mid_start);
        int hs;
        bit prev_err;
        prev_err = m_err;
        build_model(len_i);
        obs_num.delete();
        hs = 0;
        start = 1'b1; len = LEN_W'(len_i); sym_valid = 1'b1; sym_in = 2'd1;
        @(negedge clk);
        checks++;
        if (num !== 2'd0 || busy !== 1'b0 || sym_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle num=%0d busy=%0b rdy=%0b done=%0b exp 0/0/0/0", tag, num, busy, sym_ready, done);
        end
        checks++;
        if (err !== prev_err) begin
            errors++;
            $display("FAIL %s idle err got %0b exp %0b", tag, err, prev_err);
        end
        @(posedge clk); #1;
        foreach (ents[i]) begin
            start     = mid_start ? 1'($urandom_range(0, 1)) : 1'b0;
            sym_valid = ents[i].dv;
            sym_in    = 2'(ents[i].ds);
            @(negedge clk);
            obs_num.push_back(int'(num));
            if (sym_ready && sym_valid) hs++;
            checks++;
            if (num !== 2'(ents[i].nm)) begin
                errors++;
                $display("FAIL %s cyc%0d num got %0d exp %0d", tag, i + 1, num, ents[i].nm);
            end
            checks++;
            if (sym_ready !== ents[i].rdy) begin
                errors++;
                $display("FAIL %s cyc%0d sym_ready got %0b exp %0b", tag, i + 1, sym_ready, ents[i].rdy);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s cyc%0d busy got %0b exp 1", tag, i + 1, busy);
            end
            checks++;
            if (done !== ents[i].dn) begin
                errors++;
                $display("FAIL %s cyc%0d done got %0b exp %0b", tag, i + 1, done, ents[i].dn);
            end
            checks++;
            if (err !== ents[i].er) begin
                errors++;
                $display("FAIL %s cyc%0d err got %0b exp %0b", tag, i + 1, err, ents[i].er);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; sym_valid = 1'b0;
        checks++;
        if (hs != m_acc) begin
            errors++;
            $display("FAIL %s handshakes got %0d exp %0d", tag, hs, m_acc);
        end
    endtask

    task automatic gen_frame(input int n);
        f_syms.delete(); f_vpat.delete();
        for (int i = 0; i < n; i++)
            f_syms.push_back(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)));
        for (int i = 0; i < n + 4; i++)
            f_vpat.push_back($urandom_range(0, 5) != 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; len = '0; sym_valid = 1'b0; sym_in = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (num !== 2'd0 || busy !== 1'b0 || sym_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset num=%0d busy=%0b rdy=%0b done=%0b err=%0b exp all 0", num, busy, sym_ready, done, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_err = 1'b0;
        sym_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (sym_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold rdy=%0b busy=%0b exp 0/0", sym_ready, busy);
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic test_basic;
        int exp_q[$];
        f_syms = '{1, 2, 3}; f_vpat = '{1, 1, 1, 1};
        run_frame("basic", 3, 1'b0);
        exp_q = '{1, 2, 3, 1, 2, 3, 0};
        checks++;
        if (obs_num != exp_q) begin
            errors++;
            $display("FAIL basic_seq got %p exp %p", obs_num, exp_q);
        end
        @(negedge clk);
        checks++;
        if (num !== 2'd0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_tail num=%0d done=%0b err=%0b busy=%0b exp 0/0/0/0", num, done, err, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_zero;
        int exp_q[$];
        f_syms.delete(); f_vpat = '{1, 1};
        run_frame("len0", 0, 1'b0);
        exp_q = '{1, 2, 3, 0};
        checks++;
        if (obs_num != exp_q) begin
            errors++;
            $display("FAIL len0_seq got %p exp %p", obs_num, exp_q);
        end
    endtask

    task automatic test_underflow;
        int exp_q[$];
        f_syms = '{2, 1}; f_vpat = '{0, 1, 1};
        run_frame("underflow", 2, 1'b0);
`ifdef COUNTING_TX_FILL_EN
        exp_q = '{1, 2, 3, 3, 2, 1, 0};
`else
        exp_q = '{1, 2, 3, 0};
`endif
        checks++;
        if (obs_num != exp_q) begin
            errors++;
            $display("FAIL underflow_seq got %p exp %p", obs_num, exp_q);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err got %0b exp 1", err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_sym;
        int exp_q[$];
        f_syms = '{0, 2}; f_vpat = '{1, 1, 1};
        run_frame("zerosym", 2, 1'b0);
        exp_q = '{1, 2, 3, 3, 2, 0};
        checks++;
        if (obs_num != exp_q) begin
            errors++;
            $display("FAIL zerosym_seq got %p exp %p", obs_num, exp_q);
        end
        // next accepted start clears the sticky err (checked cycle by cycle)
        f_syms = '{3}; f_vpat = '{1, 1};
        run_frame("errclear", 1, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL errclear err got %0b exp 0", err);
        end
    endtask

    task automatic test_saturate;
        f_syms.delete(); f_vpat.delete();
        for (int i = 0; i < 20; i++) begin
            f_syms.push_back(int'($urandom_range(1, 3)));
            f_vpat.push_back(1'b1);
        end
        run_frame("saturate", 20, 1'b1);
        checks++;
        if (obs_num.size() != 2 + int'(MAX_LEN) + 2) begin
            errors++;
            $display("FAIL saturate_len got %0d exp %0d", obs_num.size(), 2 + MAX_LEN + 2);
        end
    endtask

    task automatic test_reset_midframe;
        start = 1'b1; len = LEN_W'(4); sym_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; sym_valid = 1'b1; sym_in = 2'd1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || num !== 2'd1) begin
            errors++;
            $display("FAIL midrst_pre busy=%0b num=%0d exp 1/1", busy, num);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (num !== 2'd0 || busy !== 1'b0 || sym_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst num=%0d busy=%0b rdy=%0b done=%0b err=%0b exp all 0", num, busy, sym_ready, done, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; sym_valid = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        f_syms = '{3, 3}; f_vpat = '{1, 1, 1};
        run_frame("after_rst", 2, 1'b0);
        checks++;
        if (obs_num.size() < 3 || obs_num[0] != 1 || obs_num[1] != 2 || obs_num[2] != 3) begin
            errors++;
            $display("FAIL after_rst_pre got %p exp 1,2,3 first", obs_num);
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) begin
            gen_frame(int'($urandom_range(0, 5)));
            run_frame("b2b", f_syms.size(), 1'b0);
        end
    endtask

    task automatic test_random;
        int n;
        for (int f = 0; f < 25; f++) begin
            n = int'($urandom_range(0, 20));
            gen_frame(n);
            run_frame("random", n, 1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_underflow();
        test_zero_sym();
        test_saturate();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
